// File: rtl/core_types_pkg.sv
// Shared types for the conditional-branch predictor: counter states,
// the DEC-to-EXE prediction snapshot and the counter step function.
package core_types_pkg;

    // 2-bit saturating counter; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_e;

    localparam bp_ctr_e     CTR_INIT     = WNT;
    localparam logic [31:0] PC_STEP      = 32'd4;
    // Widest table index the snapshot can carry.
    localparam int          BP_IDX_MAX_W = 16;

    typedef struct packed {
        logic                    valid;
        logic [31:0]             pc;
        logic [31:0]             target;
        logic                    pred;
        logic [BP_IDX_MAX_W-1:0] idx;
    } bp_exe_entry_t;

    // Saturating step: increments on taken, decrements on not taken.
    function automatic bp_ctr_e ctr_next(bp_ctr_e c, logic up);
        logic [1:0] v;
        v = c;
        if (up && v != 2'b11) begin
            v = v + 2'd1;
        end else if (!up && v != 2'b00) begin
            v = v - 2'd1;
        end
        return bp_ctr_e'(v);
    endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter2.sv
// One 2-bit saturating up/down counter of the branch history table.
// Ports: Clock, nReset, i_en (step this cycle), i_up (1=taken), o_ctr.
module sat_counter2
    import core_types_pkg::*;
(
    input  logic    Clock,
    input  logic    nReset,
    input  logic    i_en,
    input  logic    i_up,
    output bp_ctr_e o_ctr
);

    bp_ctr_e r_ctr;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_ctr <= CTR_INIT;
        end else if (i_en) begin
            r_ctr <= ctr_next(r_ctr, i_up);
        end
    end

    assign o_ctr = r_ctr;

endmodule

// File: rtl/branch_predictor_bht.sv
// Conditional-branch predictor: PC-indexed (optionally gshare) table of
// 2-bit counters. Predicts in DEC, resolves in EXE one cycle later.
// Ports: Clock, nReset; DEC side dec_valid/dec_is_cond/dec_pc/dec_target,
// stall, flush_in; EXE side exe_taken. Outputs predict_taken,
// predict_target, mispredict, redirect_pc, branch_count, mispredict_count.
module branch_predictor_bht
    import core_types_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int HIST_W = 6,
    parameter int GSHARE = 0,
    parameter int STAT_W = 32
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              dec_valid,
    input  logic              dec_is_cond,
    input  logic [31:0]       dec_pc,
    input  logic [31:0]       dec_target,
    input  logic              stall,
    input  logic              flush_in,
    input  logic              exe_taken,
    output logic              predict_taken,
    output logic [31:0]       predict_target,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] mispredict_count
);

    localparam int DEPTH = 1 << IDX_W;

    logic [HIST_W-1:0] r_ghr;
    bp_exe_entry_t     r_exe;
    logic [STAT_W-1:0] r_branch_count;
    logic [STAT_W-1:0] r_mispredict_count;

    bp_ctr_e           w_ctr [DEPTH];
    bp_ctr_e           w_rd_ctr;
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_exe_idx;
    logic              w_resolve;
    logic              w_load;
    logic              w_unused;

    assign w_exe_idx = r_exe.idx[IDX_W-1:0];
    assign w_unused  = ^{r_exe.idx[BP_IDX_MAX_W-1:IDX_W],
                         dec_pc[31:IDX_W+2], dec_pc[1:0]};

    always_comb begin
        w_idx = dec_pc[IDX_W+1:2];
        if (GSHARE != 0) begin
            w_idx = w_idx ^ IDX_W'(r_ghr);
        end
    end

    // A flushed EXE slot is discarded without touching any state.
    assign w_resolve = r_exe.valid & ~flush_in;

    // Bypass so a lookup in the resolve cycle sees the updated counter.
    always_comb begin
        w_rd_ctr = w_ctr[w_idx];
        if (w_resolve && w_exe_idx == w_idx) begin
            w_rd_ctr = ctr_next(w_ctr[w_idx], exe_taken);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
        sat_counter2 u_ctr (
            .Clock  (Clock),
            .nReset (nReset),
            .i_en   (w_resolve && w_exe_idx == IDX_W'(g)),
            .i_up   (exe_taken),
            .o_ctr  (w_ctr[g])
        );
    end

    assign predict_taken  = dec_valid & dec_is_cond & ~flush_in
                          & w_rd_ctr[1];
    assign predict_target = predict_taken ? dec_target : '0;

    assign mispredict  = w_resolve & (r_exe.pred ^ exe_taken);
    assign redirect_pc = !mispredict ? '0
                       : exe_taken   ? r_exe.target
                       : r_exe.pc + PC_STEP;

    // A branch behind a mispredict is wrong-path and never enters EXE.
    assign w_load = dec_valid & dec_is_cond & ~stall & ~flush_in
                  & ~mispredict;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_exe <= '0;
        end else if (w_load) begin
            r_exe <= '{valid:  1'b1,
                       pc:     dec_pc,
                       target: dec_target,
                       pred:   w_rd_ctr[1],
                       idx:    BP_IDX_MAX_W'(w_idx)};
        end else begin
            r_exe.valid <= 1'b0;
        end
    end

    // History is non-speculative: shifted only at resolution.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_ghr <= '0;
        end else if (w_resolve) begin
            r_ghr <= HIST_W'({r_ghr, exe_taken});
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_resolve) begin
            if (r_branch_count != '1) begin
                r_branch_count <= r_branch_count + 1'b1;
            end
            if (mispredict && r_mispredict_count != '1) begin
                r_mispredict_count <= r_mispredict_count + 1'b1;
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: bimodal instance (a_*) and a
// gshare instance with 2-bit history (b_*).
module tb_branch_predictor_bht;

    logic        Clock;
    logic        nReset;
    logic        dec_valid, dec_is_cond, stall, flush_in, exe_taken;
    logic [31:0] dec_pc, dec_target;
    logic        pt, mp;
    logic [31:0] ptgt, rd;
    logic [31:0] bc, mc;

    logic        b_dec_valid, b_dec_is_cond, b_stall, b_flush, b_exe_taken;
    logic [31:0] b_dec_pc, b_dec_target;
    logic        b_pt, b_mp;
    logic [31:0] b_ptgt, b_rd;
    logic [31:0] b_bc, b_mc;

    int n_vec = 0;
    int n_err = 0;

    branch_predictor_bht #(
        .IDX_W(6), .HIST_W(6), .GSHARE(0), .STAT_W(32)
    ) dut_a (
        .Clock            (Clock),
        .nReset           (nReset),
        .dec_valid        (dec_valid),
        .dec_is_cond      (dec_is_cond),
        .dec_pc           (dec_pc),
        .dec_target       (dec_target),
        .stall            (stall),
        .flush_in         (flush_in),
        .exe_taken        (exe_taken),
        .predict_taken    (pt),
        .predict_target   (ptgt),
        .mispredict       (mp),
        .redirect_pc      (rd),
        .branch_count     (bc),
        .mispredict_count (mc)
    );

    branch_predictor_bht #(
        .IDX_W(6), .HIST_W(2), .GSHARE(1), .STAT_W(32)
    ) dut_b (
        .Clock            (Clock),
        .nReset           (nReset),
        .dec_valid        (b_dec_valid),
        .dec_is_cond      (b_dec_is_cond),
        .dec_pc           (b_dec_pc),
        .dec_target       (b_dec_target),
        .stall            (b_stall),
        .flush_in         (b_flush),
        .exe_taken        (b_exe_taken),
        .predict_taken    (b_pt),
        .predict_target   (b_ptgt),
        .mispredict       (b_mp),
        .redirect_pc      (b_rd),
        .branch_count     (b_bc),
        .mispredict_count (b_mc)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Inputs change 1 time unit after the rising edge; checks 4 later.
    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_dec(input logic v, input logic [31:0] pc,
                           input logic [31:0] tgt);
        dec_valid   = v;
        dec_is_cond = v;
        dec_pc      = pc;
        dec_target  = tgt;
    endtask

    task automatic set_b(input logic v, input logic [31:0] pc,
                         input logic [31:0] tgt);
        b_dec_valid   = v;
        b_dec_is_cond = v;
        b_dec_pc      = pc;
        b_dec_target  = tgt;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        set_dec(1'b1, 32'h100, 32'h200);
        #2;
        n_vec++; if (pt !== 1'b0) begin n_err++; $display("FAIL rst_pt: got %b want 0", pt); end
        n_vec++; if (ptgt !== 32'h0) begin n_err++; $display("FAIL rst_ptgt: got %h want 0", ptgt); end
        n_vec++; if (mp !== 1'b0) begin n_err++; $display("FAIL rst_mp: got %b want 0", mp); end
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_rd: got %h want 0", rd); end
        n_vec++; if (bc !== 32'd0) begin n_err++; $display("FAIL rst_bc: got %0d want 0", bc); end
        n_vec++; if (mc !== 32'd0) begin n_err++; $display("FAIL rst_mc: got %0d want 0", mc); end
        set_dec(1'b0, 32'h0, 32'h0);
        @(negedge Clock);
        nReset = 1'b1;
    endtask

    task automatic test_first_branch();
        next_cycle(); set_dec(1'b1, 32'h100, 32'h200); exe_taken = 1'b0; #4;
        n_vec++; if (pt !== 1'b0) begin n_err++; $display("FAIL first_pt: got %b want 0", pt); end
        n_vec++; if (ptgt !== 32'h0) begin n_err++; $display("FAIL first_ptgt: got %h want 0", ptgt); end
        next_cycle(); set_dec(1'b0, 32'h0, 32'h0); exe_taken = 1'b1; #4;
        n_vec++; if (mp !== 1'b1) begin n_err++; $display("FAIL first_mp: got %b want 1", mp); end
        n_vec++; if (rd !== 32'h200) begin n_err++; $display("FAIL first_rd: got %h want 200", rd); end
        next_cycle(); exe_taken = 1'b0; #4;
        n_vec++; if (mp !== 1'b0) begin n_err++; $display("FAIL first_bubble_mp: got %b want 0", mp); end
        n_vec++; if (bc !== 32'd1) begin n_err++; $display("FAIL first_bc: got %0d want 1", bc); end
        n_vec++; if (mc !== 32'd1) begin n_err++; $display("FAIL first_mc: got %0d want 1", mc); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 2; i++) begin
            next_cycle(); set_dec(1'b1, 32'h100, 32'h200); exe_taken = 1'b0; #4;
            n_vec++; if (pt !== 1'b1) begin n_err++; $display("FAIL sat_pt%0d: got %b want 1", i, pt); end
            n_vec++; if (ptgt !== 32'h200) begin n_err++; $display("FAIL sat_ptgt%0d: got %h want 200", i, ptgt); end
            next_cycle(); set_dec(1'b0, 32'h0, 32'h0); exe_taken = 1'b1; #4;
            n_vec++; if (mp !== 1'b0) begin n_err++; $display("FAIL sat_mp%0d: got %b want 0", i, mp); end
            n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL sat_rd%0d: got %h want 0", i, rd); end
        end
        // Counter is 11; one not-taken leaves it at 10.
        next_cycle(); set_dec(1'b1, 32'h100, 32'h200); exe_taken = 1'b0; #4;
        n_vec++; if (pt !== 1'b1) begin n_err++; $display("FAIL sat_nt_pt: got %b want 1", pt); end
        next_cycle(); set_dec(1'b0, 32'h0, 32'h0); exe_taken = 1'b0; #4;
        n_vec++; if (mp !== 1'b1) begin n_err++; $display("FAIL sat_nt_mp: got %b want 1", mp); end
        n_vec++; if (rd !== 32'h104) begin n_err++; $display("FAIL sat_nt_rd: got %h want 104", rd); end
    endtask

    task automatic test_stall();
        next_cycle(); stall = 1'b1; set_dec(1'b1, 32'h100, 32'h200); #4;
        n_vec++; if (pt !== 1'b1) begin n_err++; $display("FAIL stall_pt: got %b want 1", pt); end
        n_vec++; if (bc !== 32'd4) begin n_err++; $display("FAIL stall_bc0: got %0d want 4", bc); end
        n_vec++; if (mc !== 32'd2) begin n_err++; $display("FAIL stall_mc0: got %0d want 2", mc); end
        next_cycle(); stall = 1'b0; set_dec(1'b0, 32'h0, 32'h0); exe_taken = 1'b0; #4;
        n_vec++; if (mp !== 1'b0) begin n_err++; $display("FAIL stall_mp: got %b want 0", mp); end
        next_cycle(); #4;
        n_vec++; if (bc !== 32'd4) begin n_err++; $display("FAIL stall_bc1: got %0d want 4", bc); end
    endtask

    task automatic test_back_to_back();
        next_cycle(); set_dec(1'b1, 32'h104, 32'h300); exe_taken = 1'b0; #4;
        n_vec++; if (pt !== 1'b0) begin n_err++; $display("FAIL b2b_pt0: got %b want 0", pt); end
        // Resolves taken from 01; same idx in DEC sees bypassed 10.
        next_cycle(); exe_taken = 1'b1; #4;
        n_vec++; if (mp !== 1'b1) begin n_err++; $display("FAIL b2b_mp1: got %b want 1", mp); end
        n_vec++; if (rd !== 32'h300) begin n_err++; $display("FAIL b2b_rd1: got %h want 300", rd); end
        n_vec++; if (pt !== 1'b1) begin n_err++; $display("FAIL b2b_bypass: got %b want 1", pt); end
        // Previous DEC was wrong-path, so EXE is empty now.
        next_cycle(); exe_taken = 1'b0; #4;
        n_vec++; if (mp !== 1'b0) begin n_err++; $display("FAIL b2b_killed: got %b want 0", mp); end
        n_vec++; if (pt !== 1'b1) begin n_err++; $display("FAIL b2b_pt2: got %b want 1", pt); end
        next_cycle(); exe_taken = 1'b1; #4;
        n_vec++; if (mp !== 1'b0) begin n_err++; $display("FAIL b2b_mp3: got %b want 0", mp); end
        n_vec++; if (pt !== 1'b1) begin n_err++; $display("FAIL b2b_pt3: got %b want 1", pt); end
        next_cycle(); set_dec(1'b0, 32'h0, 32'h0); exe_taken = 1'b0; #4;
        n_vec++; if (mp !== 1'b1) begin n_err++; $display("FAIL b2b_mp4: got %b want 1", mp); end
        n_vec++; if (rd !== 32'h108) begin n_err++; $display("FAIL b2b_rd4: got %h want 108", rd); end
        next_cycle(); #4;
        n_vec++; if (bc !== 32'd7) begin n_err++; $display("FAIL b2b_bc: got %0d want 7", bc); end
        n_vec++; if (mc !== 32'd4) begin n_err++; $display("FAIL b2b_mc: got %0d want 4", mc); end
    endtask

    task automatic test_wrap();
        next_cycle(); set_dec(1'b1, 32'hFFFF_FFFC, 32'h40); exe_taken = 1'b0; #4;
        n_vec++; if (pt !== 1'b0) begin n_err++; $display("FAIL wrap_pt0: got %b want 0", pt); end
        next_cycle(); set_dec(1'b0, 32'h0, 32'h0); exe_taken = 1'b1; #4;
        n_vec++; if (mp !== 1'b1) begin n_err++; $display("FAIL wrap_mp0: got %b want 1", mp); end
        next_cycle(); set_dec(1'b1, 32'hFFFF_FFFC, 32'h40); exe_taken = 1'b0; #4;
        n_vec++; if (pt !== 1'b1) begin n_err++; $display("FAIL wrap_pt1: got %b want 1", pt); end
        next_cycle(); set_dec(1'b0, 32'h0, 32'h0); exe_taken = 1'b0; #4;
        n_vec++; if (mp !== 1'b1) begin n_err++; $display("FAIL wrap_mp1: got %b want 1", mp); end
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL wrap_rd: got %h want 0", rd); end
        next_cycle(); stall = 1'b1; set_dec(1'b1, 32'hFFFF_FFFC, 32'h40); #4;
        n_vec++; if (pt !== 1'b0) begin n_err++; $display("FAIL wrap_dec: got %b want 0", pt); end
        n_vec++; if (bc !== 32'd9) begin n_err++; $display("FAIL wrap_bc: got %0d want 9", bc); end
        n_vec++; if (mc !== 32'd6) begin n_err++; $display("FAIL wrap_mc: got %0d want 6", mc); end
        stall = 1'b0; set_dec(1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_flush();
        next_cycle(); set_dec(1'b1, 32'h108, 32'h500); exe_taken = 1'b0; #4;
        n_vec++; if (pt !== 1'b0) begin n_err++; $display("FAIL fl_pt0: got %b want 0", pt); end
        next_cycle(); set_dec(1'b0, 32'h0, 32'h0); exe_taken = 1'b1; flush_in = 1'b1; #4;
        n_vec++; if (mp !== 1'b0) begin n_err++; $display("FAIL fl_mp: got %b want 0", mp); end
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL fl_rd: got %h want 0", rd); end
        next_cycle(); flush_in = 1'b0; stall = 1'b1; set_dec(1'b1, 32'h108, 32'h500); #4;
        n_vec++; if (pt !== 1'b0) begin n_err++; $display("FAIL fl_ctr: got %b want 0", pt); end
        n_vec++; if (bc !== 32'd9) begin n_err++; $display("FAIL fl_bc: got %0d want 9", bc); end
        n_vec++; if (mc !== 32'd6) begin n_err++; $display("FAIL fl_mc: got %0d want 6", mc); end
        // Flush in DEC suppresses a taken prediction and the EXE load.
        next_cycle(); stall = 1'b0; flush_in = 1'b1; set_dec(1'b1, 32'h100, 32'h200); #4;
        n_vec++; if (pt !== 1'b0) begin n_err++; $display("FAIL fl_dec_pt: got %b want 0", pt); end
        next_cycle(); flush_in = 1'b0; set_dec(1'b0, 32'h0, 32'h0); exe_taken = 1'b0; #4;
        n_vec++; if (mp !== 1'b0) begin n_err++; $display("FAIL fl_dec_kill: got %b want 0", mp); end
        next_cycle(); #4;
        n_vec++; if (bc !== 32'd9) begin n_err++; $display("FAIL fl_bc1: got %0d want 9", bc); end
    endtask

    task automatic test_gshare();
        // T at pc 0x10 (idx 4), GHR 00 -> 01.
        next_cycle(); set_b(1'b1, 32'h10, 32'h80); b_exe_taken = 1'b0; #4;
        n_vec++; if (b_pt !== 1'b0) begin n_err++; $display("FAIL gs_pt0: got %b want 0", b_pt); end
        next_cycle(); set_b(1'b0, 32'h0, 32'h0); b_exe_taken = 1'b1; #4;
        n_vec++; if (b_mp !== 1'b1) begin n_err++; $display("FAIL gs_mp0: got %b want 1", b_mp); end
        // pc 0x10 now indexes 4^1=5, a fresh counter.
        next_cycle(); set_b(1'b1, 32'h10, 32'h80); b_exe_taken = 1'b0; #4;
        n_vec++; if (b_pt !== 1'b0) begin n_err++; $display("FAIL gs_pt1: got %b want 0", b_pt); end
        next_cycle(); set_b(1'b0, 32'h0, 32'h0); b_exe_taken = 1'b1; #4;
        n_vec++; if (b_mp !== 1'b1) begin n_err++; $display("FAIL gs_mp1: got %b want 1", b_mp); end
        // GHR=11: pc 0x0 indexes 3.
        next_cycle(); set_b(1'b1, 32'h0, 32'h40); b_exe_taken = 1'b0; #4;
        n_vec++; if (b_pt !== 1'b0) begin n_err++; $display("FAIL gs_pt2: got %b want 0", b_pt); end
        next_cycle(); set_b(1'b0, 32'h0, 32'h0); b_exe_taken = 1'b1; #4;
        n_vec++; if (b_mp !== 1'b1) begin n_err++; $display("FAIL gs_mp2: got %b want 1", b_mp); end
        n_vec++; if (b_rd !== 32'h40) begin n_err++; $display("FAIL gs_rd2: got %h want 40", b_rd); end
        next_cycle(); b_exe_taken = 1'b0; b_stall = 1'b1; set_b(1'b1, 32'h0, 32'h40); #4;
        n_vec++; if (b_pt !== 1'b1) begin n_err++; $display("FAIL gs_ctr3: got %b want 1", b_pt); end
        // pc 0xC indexes 3^3=0, which must still be 01.
        next_cycle(); set_b(1'b1, 32'hC, 32'h40); #4;
        n_vec++; if (b_pt !== 1'b0) begin n_err++; $display("FAIL gs_ctr0: got %b want 0", b_pt); end
        n_vec++; if (b_bc !== 32'd3) begin n_err++; $display("FAIL gs_bc: got %0d want 3", b_bc); end
        n_vec++; if (b_mc !== 32'd3) begin n_err++; $display("FAIL gs_mc: got %0d want 3", b_mc); end
        b_stall = 1'b0; set_b(1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_async_reset();
        next_cycle(); stall = 1'b1; set_dec(1'b1, 32'h100, 32'h200); #2;
        n_vec++; if (pt !== 1'b1) begin n_err++; $display("FAIL ar_pre_pt: got %b want 1", pt); end
        nReset = 1'b0; #1;
        n_vec++; if (pt !== 1'b0) begin n_err++; $display("FAIL ar_pt: got %b want 0", pt); end
        n_vec++; if (bc !== 32'd0) begin n_err++; $display("FAIL ar_bc: got %0d want 0", bc); end
        n_vec++; if (mc !== 32'd0) begin n_err++; $display("FAIL ar_mc: got %0d want 0", mc); end
        n_vec++; if (b_bc !== 32'd0) begin n_err++; $display("FAIL ar_b_bc: got %0d want 0", b_bc); end
        stall = 1'b0; set_dec(1'b0, 32'h0, 32'h0);
        @(negedge Clock);
        nReset = 1'b1;
    endtask

    initial begin
        stall = 1'b0; flush_in = 1'b0; exe_taken = 1'b0;
        set_dec(1'b0, 32'h0, 32'h0);
        b_stall = 1'b0; b_flush = 1'b0; b_exe_taken = 1'b0;
        set_b(1'b0, 32'h0, 32'h0);
        test_reset();
        test_first_branch();
        test_saturate();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_gshare();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
